// File: rtl/ram_pkg.sv
// Shared constants and the parity helper for the scratch RAM.
// RAM_PARITY_EN selects whether the parity bit is generated.
package ram_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int WORD_W = DATA_W + 1;

  // Even parity: XOR reduction, so {parity, data} always holds an even count of ones.
  function automatic logic parity(input logic [DATA_W-1:0] x);
    return ^x;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Storage array plus per-word valid bits for the scratch RAM.
// Read data is combinational; the top level registers it.
// Valid bits clear asynchronously, but the stored words do not.
module ram_array #(
  parameter int DATA_W = ram_pkg::DATA_W,
  parameter int ADDR_W = ram_pkg::ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  // Word storage: no reset, so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

  // Valid bits: set on write, cleared by reset.
  // This makes stale contents read as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[addr] <= 1'b1;
    end
  end

  assign rd_data  = mem_q[addr];
  assign rd_valid = valid_q[addr];

endmodule

// File: rtl/ram_parity_sp.sv
// Single-port scratch RAM with a parity bit on every read word.
// The accessed address is echoed on addr_out.
// With RAM_PARITY_EN undefined, data_out[DATA_W] is tied 0.
module ram_parity_sp #(
  parameter int DATA_W = ram_pkg::DATA_W,
  parameter int ADDR_W = ram_pkg::ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  output logic [DATA_W:0]   data_out,
  output logic [ADDR_W-1:0] addr_out
);

  import ram_pkg::*;

  logic              in_range;
  logic              wr_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              par_wr;
  logic              par_rd;
  logic [DATA_W:0]   data_out_d;
  logic [DATA_W:0]   data_out_q;
  logic [ADDR_W-1:0] addr_out_q;

  // The range check is only needed when the array is shallower than the address space.
  generate
    if (DEPTH >= 2**ADDR_W) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_partial_range
      assign in_range = (int'({1'b0, addr}) < DEPTH);
    end
  endgenerate

  assign wr_en = ~we & in_range;

  ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .addr     (addr),
    .wr_data  (data_in),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

`ifdef RAM_PARITY_EN
  assign par_wr = parity(data_in);
  assign par_rd = parity(rd_data);
`else
  assign par_wr = 1'b0;
  assign par_rd = 1'b0;
`endif

  // Next output word.
  // A write forwards the incoming data (write-first).
  // Invalid or out-of-range accesses return zero.
  always_comb begin
    data_out_d = '0;
    if (in_range) begin
      if (!we) begin
        data_out_d = {par_wr, data_in};
      end else if (rd_valid) begin
        data_out_d = {par_rd, rd_data};
      end
    end
  end

  // Output registers: updated on every edge and cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      addr_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
      addr_out_q <= addr;
    end
  end

  assign data_out = data_out_q;
  assign addr_out = addr_out_q;

endmodule

// File: tb/tb_ram_parity_sp.sv
// Directed testbench for ram_parity_sp.
// Expected words are hand-computed with parity.
// When RAM_PARITY_EN is undefined, bit 8 of each expected word is expected to be 0.
module tb_ram_parity_sp;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic [7:0] addr;
  logic       we;
  logic [8:0] data_out;
  logic [7:0] addr_out;

  int n_vec;
  int n_err;

  ram_parity_sp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .addr     (addr),
    .we       (we),
    .data_out (data_out),
    .addr_out (addr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed {parity, data} words for data 0..7.
  logic [8:0] fill_exp [8];
  initial begin
    fill_exp[0] = 9'h000; fill_exp[1] = 9'h101; fill_exp[2] = 9'h102; fill_exp[3] = 9'h003;
    fill_exp[4] = 9'h104; fill_exp[5] = 9'h005; fill_exp[6] = 9'h006; fill_exp[7] = 9'h107;
  end

  // Applies the build configuration: without parity, bit 8 is expected to read 0.
  function automatic logic [8:0] cfg(input logic [8:0] w);
`ifdef RAM_PARITY_EN
    return w;
`else
    return {1'b0, w[7:0]};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Apply one access and wait for its edge; outputs are then sampled 1 ns later.
  task automatic access(input logic w_n, input logic [7:0] a, input logic [7:0] d);
    we      = w_n;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    we      = 1'b1;
    addr    = 8'h00;
    data_in = 8'h00;

    // 1. Reset while clocking, then read never-written locations.
    repeat (3) @(posedge clk);
    #1;
    chk("rst data_out", 32'(data_out), 32'h000);
    chk("rst addr_out", 32'(addr_out), 32'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      access(1'b1, 8'(i), 8'h00);
      chk($sformatf("blank rd %0d", i), 32'(data_out), 32'h000);
    end

    // 2. Fill: write-first, so data_out shows the written word.
    for (int i = 0; i < 8; i++) begin
      access(1'b0, 8'(i), 8'(i));
      chk($sformatf("fill data %0d", i), 32'(data_out), 32'(cfg(fill_exp[i])));
      chk($sformatf("fill addr %0d", i), 32'(addr_out), 32'(i));
    end

    // 3. Read back the filled words.
    for (int i = 0; i < 8; i++) begin
      access(1'b1, 8'(i), 8'hEE);
      chk($sformatf("rdbk data %0d", i), 32'(data_out), 32'(cfg(fill_exp[i])));
      chk($sformatf("rdbk addr %0d", i), 32'(addr_out), 32'(i));
    end

    // 4. Exercise the top address with write-then-read.
    access(1'b0, 8'hFF, 8'hA5);
    chk("wr FF=A5", 32'(data_out), 32'(cfg(9'h0A5)));
    chk("wr FF addr", 32'(addr_out), 32'hFF);
    access(1'b1, 8'hFF, 8'h00);
    chk("rd FF", 32'(data_out), 32'(cfg(9'h0A5)));
    access(1'b0, 8'hFF, 8'h01);
    chk("wr FF=01", 32'(data_out), 32'(cfg(9'h101)));
    access(1'b1, 8'h05, 8'h00);
    chk("rd 5 again", 32'(data_out), 32'(cfg(9'h005)));

    // 5. Pulse reset between edges; outputs must clear without a clock edge.
    #1;
    rst_n = 1'b0;
    #1;
    chk("async clr data", 32'(data_out), 32'h000);
    chk("async clr addr", 32'(addr_out), 32'h00);
    rst_n = 1'b1;
    access(1'b1, 8'h03, 8'h00);
    chk("post-rst rd 3", 32'(data_out), 32'h000);
    chk("post-rst addr 3", 32'(addr_out), 32'h03);
    access(1'b1, 8'hFF, 8'h00);
    chk("post-rst rd FF", 32'(data_out), 32'h000);

    // Rewriting a location makes it readable again.
    access(1'b0, 8'h03, 8'h07);
    chk("rewr 3", 32'(data_out), 32'(cfg(9'h107)));
    access(1'b1, 8'h03, 8'h00);
    chk("rerd 3", 32'(data_out), 32'(cfg(9'h107)));
    access(1'b1, 8'h04, 8'h00);
    chk("still invalid 4", 32'(data_out), 32'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
